// File: rtl/dtw_core_sched.sv
// dtw_core_sched: job scheduler for the multi-core DTW accelerator.
//
// Runs the one-time reference load through the reference loader, then hands
// query jobs round-robin to NUM_CORES DTW cores. It tracks which cores own a
// job and returns each result on a valid/ready stream, tagged with the job ID
// and the index of the core that produced it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_ref_len_in           reference length, latched when a load starts
//   load_req_in              one-cycle pulse requesting a reference (re)load
//   ldr_rs_out               loader run-start pulse (load start or job dispatch)
//   ldr_op_mode_out          loader mode: 1 load, 0 normal read
//   ldr_ref_len_out          latched reference length for the loader
//   ldr_busy_in              loader busy
//   ldr_load_done_in         loader load-complete flag
//   job_valid_in/job_id_in   job request; job_ready_out accepts it
//   core_start_out           per-core one-cycle start pulse
//   core_done_in             per-core one-cycle done pulse
//   core_result_in           per-core result slices
//   res_valid_out/res_ready_in, res_data_out, res_id_out, res_core_out
//                            result stream
//   ref_loaded_out           reference valid
//   err_out                  sticky errors: [0] load timeout, [1] stray done
//   dbg_state_out            FSM state
module dtw_core_sched #(
  parameter int NUM_CORES        = 4,
  parameter int ID_WIDTH         = 8,
  parameter int RES_WIDTH        = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int TIMEOUT_WIDTH    = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REFMEM_PTR_WIDTH-1:0]      cfg_ref_len_in,
  input  logic                             load_req_in,
  output logic                             ldr_rs_out,
  output logic                             ldr_op_mode_out,
  output logic [REFMEM_PTR_WIDTH-1:0]      ldr_ref_len_out,
  input  logic                             ldr_busy_in,
  input  logic                             ldr_load_done_in,
  input  logic                             job_valid_in,
  input  logic [ID_WIDTH-1:0]              job_id_in,
  output logic                             job_ready_out,
  output logic [NUM_CORES-1:0]             core_start_out,
  input  logic [NUM_CORES-1:0]             core_done_in,
  input  logic [NUM_CORES*RES_WIDTH-1:0]   core_result_in,
  output logic                             res_valid_out,
  input  logic                             res_ready_in,
  output logic [RES_WIDTH-1:0]             res_data_out,
  output logic [ID_WIDTH-1:0]              res_id_out,
  output logic [$clog2(NUM_CORES)-1:0]     res_core_out,
  output logic                             ref_loaded_out,
  output logic [1:0]                       err_out,
  output logic [1:0]                       dbg_state_out
);

  localparam int CW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_START = 2'd1,
    S_LOAD_WAIT  = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic                     load_pend;
  logic                     busy_seen;
  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic [NUM_CORES-1:0]     alloc, pend;
  logic [CW-1:0]            rr_ptr, res_ptr;
  logic                     disp_vld_p0;
  logic [ID_WIDTH-1:0]      id_reg  [NUM_CORES];
  logic [RES_WIDTH-1:0]     res_reg [NUM_CORES];

  // First set bit of mask at or after ptr, wrapping modulo NUM_CORES.
  // Returns {found, index}; scanning downward lets the nearest hit win.
  function automatic logic [CW:0] pick_rr(input logic [NUM_CORES-1:0] mask,
                                          input logic [CW-1:0] ptr);
    logic [CW:0] r;
    int j;
    r = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (mask[j]) r = {1'b1, CW'(j)};
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] k);
    return (int'(k) == NUM_CORES - 1) ? '0 : k + 1'b1;
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [CW-1:0] k);
    logic [NUM_CORES-1:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  logic                 idle_clean, load_done_ok, wdog_exp;
  logic                 job_fire, res_load, res_fire;
  logic [CW:0]          disp_pick, res_pick;
  logic [CW-1:0]        disp_k, res_k;
  logic [NUM_CORES-1:0] done_ok, done_bad;

  // A reload may only start once every core is free and every result drained.
  assign idle_clean   = (alloc == '0) && (pend == '0);
  assign load_done_ok = busy_seen && ldr_load_done_in && !ldr_busy_in;
  assign wdog_exp     = &wdog;
  assign job_fire     = job_valid_in && job_ready_out;
  assign disp_pick    = pick_rr(~alloc, rr_ptr);
  assign disp_k       = disp_pick[CW-1:0];
  assign res_pick     = pick_rr(pend, res_ptr);
  assign res_k        = res_pick[CW-1:0];
  assign res_load     = !res_valid_out && res_pick[CW];
  assign res_fire     = res_valid_out && res_ready_in;
  assign done_ok      = core_done_in & alloc;
  assign done_bad     = core_done_in & ~alloc;
  assign dbg_state_out = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_pend && idle_clean) state_nxt = S_LOAD_START;
        else if (ref_loaded_out)     state_nxt = S_RUN;
      end
      S_LOAD_START: state_nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (load_done_ok)  state_nxt = S_RUN;
        else if (wdog_exp) state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (load_pend && idle_clean) state_nxt = S_LOAD_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The loader run-start also fires (in read mode) the cycle after a dispatch.
  always_comb begin
    ldr_rs_out      = disp_vld_p0;
    ldr_op_mode_out = 1'b0;
    job_ready_out   = 1'b0;
    case (state)
      S_LOAD_START: begin
        ldr_rs_out      = 1'b1;
        ldr_op_mode_out = 1'b1;
      end
      S_LOAD_WAIT: ldr_op_mode_out = 1'b1;
      S_RUN:       job_ready_out = !load_pend && (alloc != '1);
      default: ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pend       <= 1'b0;
      busy_seen       <= 1'b0;
      wdog            <= '0;
      ref_loaded_out  <= 1'b0;
      err_out         <= '0;
      alloc           <= '0;
      pend            <= '0;
      rr_ptr          <= '0;
      res_ptr         <= '0;
      core_start_out  <= '0;
      disp_vld_p0     <= 1'b0;
      res_valid_out   <= 1'b0;
      res_data_out    <= '0;
      res_id_out      <= '0;
      res_core_out    <= '0;
      ldr_ref_len_out <= '0;
    end else begin
      // A request arriving while the load starts is kept for a second load.
      load_pend <= (load_pend && (state != S_LOAD_START)) || load_req_in;

      if (state_nxt == S_LOAD_START) ldr_ref_len_out <= cfg_ref_len_in;

      if (state == S_LOAD_START) begin
        wdog           <= '0;
        busy_seen      <= 1'b0;
        ref_loaded_out <= 1'b0;
      end else if (state == S_LOAD_WAIT) begin
        wdog      <= wdog + 1'b1;
        busy_seen <= busy_seen | ldr_busy_in;
        if (load_done_ok)  ref_loaded_out <= 1'b1;
        else if (wdog_exp) err_out[0]     <= 1'b1;
      end

      if (|done_bad) err_out[1] <= 1'b1;

      // Dispatch stage: start pulse goes out one cycle after the handshake
      core_start_out <= '0;
      disp_vld_p0    <= job_fire;
      if (job_fire) begin
        core_start_out <= onehot(disp_k);
        rr_ptr         <= next_ptr(disp_k);
      end

      // A core stays allocated until its result leaves on the output stream.
      alloc <= (alloc | (job_fire ? onehot(disp_k) : '0))
               & ~(res_fire ? onehot(res_core_out) : '0);
      pend  <= (pend | done_ok) & ~(res_load ? onehot(res_k) : '0);

      // Output stage: refill only when empty, hold while stalled
      if (res_load) begin
        res_valid_out <= 1'b1;
        res_data_out  <= res_reg[res_k];
        res_id_out    <= id_reg[res_k];
        res_core_out  <= res_k;
        res_ptr       <= next_ptr(res_k);
      end else if (res_fire) begin
        res_valid_out <= 1'b0;
      end
    end
  end

  // Per-core job ID and result holding registers
  always_ff @(posedge clk) begin
    if (job_fire) id_reg[disp_k] <= job_id_in;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (done_ok[k]) res_reg[k] <= core_result_in[k*RES_WIDTH +: RES_WIDTH];
    end
  end

endmodule
